// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: ID-stage instruction tags toward the controller,
// pipeline enables, bubbles and forwarding selects back to the datapath.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_is_md;
  logic                  ex_branch_taken;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  ex_hold;
  logic                  exmem_bubble;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic                  md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
           id_regwrite, id_memread, id_is_md, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold,
           exmem_bubble, forward_a, forward_b, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
           id_regwrite, id_memread, id_is_md, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold,
           exmem_bubble, forward_a, forward_b, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: shadow register tags drive
// forwarding selects, load-use stalls, branch flushes and the mult/div EX hold.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ADV_NORMAL = 2'b00,
    ADV_BUBBLE = 2'b01,
    ADV_HOLD   = 2'b10
  } adv_e;

  localparam int                    CNT_W      = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CNT_W-1:0]      MD_LOAD    = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic                  MD_HOLD_EN = (MD_LATENCY > 1);
  localparam logic [REG_ADDR_W-1:0] ZERO_TAG   = {REG_ADDR_W{1'b0}};

  // $0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] tag,
    input logic                  em_wr,
    input logic [REG_ADDR_W-1:0] em_dst,
    input logic                  mw_wr,
    input logic [REG_ADDR_W-1:0] mw_dst
  );
    logic [1:0] sel;
    if (em_wr && (em_dst != ZERO_TAG) && (em_dst == tag)) begin
      sel = 2'b10;
    end else if (mw_wr && (mw_dst != ZERO_TAG) && (mw_dst == tag)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  state_e                state_r;
  state_e                state_n_s;
  logic [CNT_W-1:0]      md_cnt_r;
  logic [CNT_W-1:0]      md_cnt_n_s;
  adv_e                  adv_s;

  logic                  idex_v_r;
  logic [REG_ADDR_W-1:0] idex_rs_r;
  logic [REG_ADDR_W-1:0] idex_rt_r;
  logic [REG_ADDR_W-1:0] idex_dst_r;
  logic                  idex_rw_r;
  logic                  idex_mr_r;
  logic                  idex_md_r;
  logic                  exmem_v_r;
  logic [REG_ADDR_W-1:0] exmem_dst_r;
  logic                  exmem_rw_r;
  logic                  memwb_v_r;
  logic [REG_ADDR_W-1:0] memwb_dst_r;
  logic                  memwb_rw_r;

  logic                  load_use_s;
  logic [1:0]            forward_a_s;
  logic [1:0]            forward_b_s;
  logic                  pc_write_s;
  logic                  ifid_write_s;
  logic                  ifid_flush_s;
  logic                  idex_bubble_s;
  logic                  ex_hold_s;
  logic                  exmem_bubble_s;
  logic                  md_busy_s;

  // Hazard detection: forwarding selects and the load-use condition
  always_comb begin
    forward_a_s = fwd_sel(idex_rs_r, exmem_v_r & exmem_rw_r, exmem_dst_r,
                          memwb_v_r & memwb_rw_r, memwb_dst_r);
    forward_b_s = fwd_sel(idex_rt_r, exmem_v_r & exmem_rw_r, exmem_dst_r,
                          memwb_v_r & memwb_rw_r, memwb_dst_r);
    load_use_s  = idex_v_r & idex_mr_r & idex_rw_r & (idex_dst_r != ZERO_TAG) & hz.id_valid &
                  ((hz.id_uses_rs & (hz.id_rs == idex_dst_r)) |
                   (hz.id_uses_rt & (hz.id_rt == idex_dst_r)));
  end

  // FSM next-state, pipeline control and shadow-advance selection
  always_comb begin
    state_n_s      = state_r;
    md_cnt_n_s     = md_cnt_r;
    adv_s          = ADV_NORMAL;
    pc_write_s     = 1'b1;
    ifid_write_s   = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    ex_hold_s      = 1'b0;
    exmem_bubble_s = 1'b0;
    md_busy_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (hz.ex_branch_taken) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          adv_s         = ADV_BUBBLE;
        end else if (load_use_s) begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_bubble_s = 1'b1;
          adv_s         = ADV_BUBBLE;
        end else begin
          adv_s = ADV_NORMAL;
        end
        // The first EX cycle of a mult/div is an ordinary cycle; the hold follows.
        if (MD_HOLD_EN && idex_v_r && idex_md_r) begin
          state_n_s  = ST_MD_BUSY;
          md_cnt_n_s = MD_LOAD;
        end else begin
          state_n_s  = ST_RUN;
          md_cnt_n_s = md_cnt_r;
        end
      end
      ST_MD_BUSY: begin
        pc_write_s     = 1'b0;
        ifid_write_s   = 1'b0;
        ex_hold_s      = 1'b1;
        exmem_bubble_s = 1'b1;
        md_busy_s      = 1'b1;
        adv_s          = ADV_HOLD;
        md_cnt_n_s     = md_cnt_r - CNT_ONE;
        if (md_cnt_r == CNT_ONE) begin
          state_n_s = ST_RUN;
        end else begin
          state_n_s = ST_MD_BUSY;
        end
      end
      default: begin
        state_n_s  = ST_RUN;
        md_cnt_n_s = CNT_ZERO;
        adv_s      = ADV_BUBBLE;
      end
    endcase
  end

  // FSM state and mult/div countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      md_cnt_r <= CNT_ZERO;
    end else begin
      state_r  <= state_n_s;
      md_cnt_r <= md_cnt_n_s;
    end
  end

  // Shadow copies of the ID/EX, EX/MEM and MEM/WB tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_v_r    <= 1'b0;
      idex_rs_r   <= ZERO_TAG;
      idex_rt_r   <= ZERO_TAG;
      idex_dst_r  <= ZERO_TAG;
      idex_rw_r   <= 1'b0;
      idex_mr_r   <= 1'b0;
      idex_md_r   <= 1'b0;
      exmem_v_r   <= 1'b0;
      exmem_dst_r <= ZERO_TAG;
      exmem_rw_r  <= 1'b0;
      memwb_v_r   <= 1'b0;
      memwb_dst_r <= ZERO_TAG;
      memwb_rw_r  <= 1'b0;
    end else begin
      memwb_v_r   <= exmem_v_r;
      memwb_dst_r <= exmem_dst_r;
      memwb_rw_r  <= exmem_rw_r;
      case (adv_s)
        ADV_NORMAL: begin
          idex_v_r    <= hz.id_valid;
          idex_rs_r   <= hz.id_valid ? hz.id_rs  : ZERO_TAG;
          idex_rt_r   <= hz.id_valid ? hz.id_rt  : ZERO_TAG;
          idex_dst_r  <= hz.id_valid ? hz.id_dst : ZERO_TAG;
          idex_rw_r   <= hz.id_valid & hz.id_regwrite;
          idex_mr_r   <= hz.id_valid & hz.id_memread;
          idex_md_r   <= hz.id_valid & hz.id_is_md;
          exmem_v_r   <= idex_v_r;
          exmem_dst_r <= idex_dst_r;
          exmem_rw_r  <= idex_rw_r;
        end
        ADV_HOLD: begin
          // ID/EX keeps its contents while EX recomputes; EX/MEM receives a NOP.
          exmem_v_r   <= 1'b0;
          exmem_dst_r <= ZERO_TAG;
          exmem_rw_r  <= 1'b0;
        end
        default: begin
          idex_v_r    <= 1'b0;
          idex_rs_r   <= ZERO_TAG;
          idex_rt_r   <= ZERO_TAG;
          idex_dst_r  <= ZERO_TAG;
          idex_rw_r   <= 1'b0;
          idex_mr_r   <= 1'b0;
          idex_md_r   <= 1'b0;
          exmem_v_r   <= idex_v_r;
          exmem_dst_r <= idex_dst_r;
          exmem_rw_r  <= idex_rw_r;
        end
      endcase
    end
  end

  // Interface drive; while reset is held the pipeline free-runs with no hazard action
  always_comb begin
    if (!rst_n) begin
      hz.pc_write     = 1'b1;
      hz.ifid_write   = 1'b1;
      hz.ifid_flush   = 1'b0;
      hz.idex_bubble  = 1'b0;
      hz.ex_hold      = 1'b0;
      hz.exmem_bubble = 1'b0;
      hz.md_busy      = 1'b0;
      hz.forward_a    = 2'b00;
      hz.forward_b    = 2'b00;
    end else begin
      hz.pc_write     = pc_write_s;
      hz.ifid_write   = ifid_write_s;
      hz.ifid_flush   = ifid_flush_s;
      hz.idex_bubble  = idex_bubble_s;
      hz.ex_hold      = ex_hold_s;
      hz.exmem_bubble = exmem_bubble_s;
      hz.md_busy      = md_busy_s;
      hz.forward_a    = forward_a_s;
      hz.forward_b    = forward_b_s;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two instances (MD_LATENCY 4 and 1)
// share directed and random stimulus and are compared to a stage-slot model.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       md;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  instr_t id_i;
  logic   id_urs;
  logic   id_urt;
  logic   br;

  // Reference model: instruction held in each later stage plus remaining hold cycles
  instr_t m_ex  [2];
  instr_t m_mem [2];
  instr_t m_wb  [2];
  int     m_hold[2];
  int     lat   [2];

  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) bus0 ();
  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) bus1 ();

  hazard_stall_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus0)
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_inputs();
    bus0.id_valid = id_i.v;  bus1.id_valid = id_i.v;
    bus0.id_rs = id_i.rs;    bus1.id_rs = id_i.rs;
    bus0.id_rt = id_i.rt;    bus1.id_rt = id_i.rt;
    bus0.id_dst = id_i.dst;  bus1.id_dst = id_i.dst;
    bus0.id_regwrite = id_i.rw; bus1.id_regwrite = id_i.rw;
    bus0.id_memread = id_i.mr;  bus1.id_memread = id_i.mr;
    bus0.id_is_md = id_i.md;    bus1.id_is_md = id_i.md;
    bus0.id_uses_rs = id_urs;   bus1.id_uses_rs = id_urs;
    bus0.id_uses_rt = id_urt;   bus1.id_uses_rt = id_urt;
    bus0.ex_branch_taken = br;  bus1.ex_branch_taken = br;
  endtask

  function automatic logic [10:0] dut_out(input int k);
    if (k == 0)
      return {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush, bus0.idex_bubble, bus0.ex_hold,
              bus0.exmem_bubble, bus0.md_busy, bus0.forward_a, bus0.forward_b};
    return {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble, bus1.ex_hold,
            bus1.exmem_bubble, bus1.md_busy, bus1.forward_a, bus1.forward_b};
  endfunction

  function automatic logic [1:0] ref_fwd(input int k, input logic [4:0] tag);
    if (m_mem[k].v && m_mem[k].rw && m_mem[k].dst != 5'd0 && m_mem[k].dst == tag) return 2'b10;
    if (m_wb[k].v && m_wb[k].rw && m_wb[k].dst != 5'd0 && m_wb[k].dst == tag) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_load_use(input int k);
    return m_ex[k].v && m_ex[k].mr && m_ex[k].rw && m_ex[k].dst != 5'd0 && id_i.v &&
           ((id_urs && id_i.rs == m_ex[k].dst) || (id_urt && id_i.rt == m_ex[k].dst));
  endfunction

  // Packed as {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble, md_busy, fa, fb}
  function automatic logic [10:0] ref_out(input int k);
    logic [3:0] fw;
    fw = {ref_fwd(k, m_ex[k].rs), ref_fwd(k, m_ex[k].rt)};
    if (!rst_n) return {7'b1100000, 4'b0000};
    if (m_hold[k] > 0) return {7'b0000111, fw};
    if (br) return {7'b1111000, fw};
    if (ref_load_use(k)) return {7'b0001000, fw};
    return {7'b1100000, fw};
  endfunction

  task automatic ref_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_hold[k] = 0;
    end
  endtask

  task automatic ref_advance();
    logic stop;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_hold[k] = 0;
      end else if (m_hold[k] > 0) begin
        m_wb[k]  = m_mem[k];
        m_mem[k] = '0;
        m_hold[k]--;
      end else begin
        stop      = br || ref_load_use(k);
        m_wb[k]   = m_mem[k];
        m_mem[k]  = m_ex[k];
        m_hold[k] = (m_ex[k].v && m_ex[k].md) ? lat[k] - 1 : 0;
        m_ex[k]   = (stop || !id_i.v) ? instr_t'('0) : id_i;
      end
    end
  endtask

  task automatic settle();
    push_inputs();
    #1;
    check_eq("model_l4", {21'd0, dut_out(0)}, {21'd0, ref_out(0)});
    check_eq("model_l1", {21'd0, dut_out(1)}, {21'd0, ref_out(1)});
  endtask

  task automatic advance();
    ref_advance();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic put(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                     input logic urs, input logic urt, input logic rw, input logic mr,
                     input logic md, input logic b);
    id_i.v = 1'b1; id_i.rs = rs; id_i.rt = rt; id_i.dst = dst;
    id_i.rw = rw; id_i.mr = mr; id_i.md = md;
    id_urs = urs; id_urt = urt; br = b;
  endtask

  task automatic nop();
    id_i = '0; id_urs = 1'b0; id_urt = 1'b0; br = 1'b0;
  endtask

  initial begin
    lat[0] = 4; lat[1] = 1;
    nop();
    ref_reset();
    repeat (2) @(negedge clk);
    settle();
    check_eq("reset_pc", {31'd0, bus0.pc_write}, 32'd1);
    check_eq("reset_fa", {30'd0, bus0.forward_a}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back ALU forwarding from both later stages
    put(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    put(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    put(5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    nop(); settle();
    check_eq("alu_fa", {30'd0, bus0.forward_a}, 32'h2);
    check_eq("alu_fb", {30'd0, bus0.forward_b}, 32'h1);
    check_eq("alu_pc", {31'd0, bus0.pc_write}, 32'd1);
    advance();

    // Double hit: EX/MEM wins
    put(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step(); step();
    put(5'd5, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    nop(); settle();
    check_eq("dbl_fa", {30'd0, bus0.forward_a}, 32'h2);
    advance();

    // Writes to $0 are never forwarded
    put(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step(); step();
    put(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    nop(); settle();
    check_eq("zero_fa", {30'd0, bus0.forward_a}, 32'h0);
    check_eq("zero_fb", {30'd0, bus0.forward_b}, 32'h0);
    advance();

    // Load-use: one stall cycle, then forward from MEM/WB
    put(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
    put(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); settle();
    check_eq("lu_pc", {31'd0, bus0.pc_write}, 32'd0);
    check_eq("lu_ifid", {31'd0, bus0.ifid_write}, 32'd0);
    check_eq("lu_bubble", {31'd0, bus0.idex_bubble}, 32'd1);
    advance();
    settle();
    check_eq("lu_release", {31'd0, bus0.pc_write}, 32'd1);
    advance();
    nop(); settle();
    check_eq("lu_fb", {30'd0, bus0.forward_b}, 32'h1);
    advance();

    // Branch beats load-use stall
    put(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
    put(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    check_eq("br_flush", {31'd0, bus0.ifid_flush}, 32'd1);
    check_eq("br_bubble", {31'd0, bus0.idex_bubble}, 32'd1);
    check_eq("br_pc", {31'd0, bus0.pc_write}, 32'd1);
    advance();
    nop(); step();

    // Mult/div hold: one normal cycle then MD_LATENCY-1 hold cycles
    put(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
    nop(); settle();
    check_eq("md_first", {31'd0, bus0.md_busy}, 32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("md_busy", {31'd0, bus0.md_busy}, 32'd1);
      check_eq("md_hold", {31'd0, bus0.ex_hold}, 32'd1);
      check_eq("md_exbub", {31'd0, bus0.exmem_bubble}, 32'd1);
      check_eq("md_pc", {31'd0, bus0.pc_write}, 32'd0);
      check_eq("md_l1", {31'd0, bus1.md_busy}, 32'd0);
      advance();
    end
    settle();
    check_eq("md_done", {31'd0, bus0.md_busy}, 32'd0);
    advance();

    // Asynchronous reset in the second hold cycle
    put(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
    nop(); step();
    settle(); advance();
    settle();
    check_eq("rst_pre_busy", {31'd0, bus0.md_busy}, 32'd1);
    rst_n = 1'b0;
    br = 1'b1;
    ref_reset();
    settle();
    check_eq("rst_busy", {31'd0, bus0.md_busy}, 32'd0);
    check_eq("rst_pc", {31'd0, bus0.pc_write}, 32'd1);
    check_eq("rst_fa", {30'd0, bus0.forward_a}, 32'h0);
    check_eq("rst_flush", {31'd0, bus0.ifid_flush}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nop(); settle();
    check_eq("rst_run", {31'd0, bus0.pc_write}, 32'd1);
    advance();
    put(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
    nop(); step();
    settle();
    check_eq("rst_resume", {31'd0, bus0.md_busy}, 32'd1);
    advance();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      id_i.v   = ($urandom_range(0, 7) != 0);
      id_i.rs  = 5'($urandom_range(0, 7));
      id_i.rt  = 5'($urandom_range(0, 7));
      id_i.dst = 5'($urandom_range(0, 7));
      id_i.rw  = 1'($urandom_range(0, 1));
      id_i.mr  = ($urandom_range(0, 3) == 0);
      id_i.md  = ($urandom_range(0, 11) == 0);
      id_urs   = 1'($urandom_range(0, 1));
      id_urt   = 1'($urandom_range(0, 1));
      br       = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        ref_reset();
        settle();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
